// File: rtl/twf_mul0_2.sv
// Stage-0_2 twiddle multiplier for the 512-point FFT.
// Drives grp_idx to twf0_2 and multiplies each beat by its twiddle.
module twf_mul0_2 #(
    parameter int LANES = 16,
    parameter int DW    = 13,
    parameter int TW    = 9,
    parameter int NGRP  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  din_valid,
    input  logic                  din_sof,
    input  logic [LANES*DW-1:0]   din_re,
    input  logic [LANES*DW-1:0]   din_im,
    output logic [4:0]            grp_idx,
    input  logic [LANES*TW-1:0]   twf_re,
    input  logic [LANES*TW-1:0]   twf_im,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  dout_sat,
    output logic [LANES*DW-1:0]   dout_re,
    output logic [LANES*DW-1:0]   dout_im
);

    localparam int PW = DW + TW + 1;
    localparam int FB = TW - 2;
    localparam logic [4:0] LAST = 5'(NGRP - 1);
    localparam logic signed [PW-1:0] HALF = PW'(1 << (FB - 1));
    localparam logic signed [PW-1:0] MAXV = PW'((1 << (DW - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = PW'(-(1 << (DW - 1)));

    logic [4:0] cnt;

    logic                 s1_valid;
    logic                 s1_last;
    logic signed [DW-1:0] s1_re [LANES];
    logic signed [DW-1:0] s1_im [LANES];

    logic                 s2_valid;
    logic                 s2_last;
    logic signed [PW-1:0] s2_re [LANES];
    logic signed [PW-1:0] s2_im [LANES];

    logic signed [PW-1:0] p_re [LANES];
    logic signed [PW-1:0] p_im [LANES];
    logic [DW-1:0]        q_re [LANES];
    logic [DW-1:0]        q_im [LANES];
    logic [LANES-1:0]     c_re;
    logic [LANES-1:0]     c_im;

    assign grp_idx = din_sof ? 5'd0 : cnt;

    // Round half up, then clamp; MSB of the result flags the clamp.
    function automatic logic [DW:0] rnd_sat(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] r;
        r = (x + HALF) >>> FB;
        if (r > MAXV) return {1'b1, MAXV[DW-1:0]};
        if (r < MINV) return {1'b1, MINV[DW-1:0]};
        return {1'b0, r[DW-1:0]};
    endfunction

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            p_re[k] = PW'(s1_re[k]) * PW'($signed(twf_re[k*TW +: TW]))
                    - PW'(s1_im[k]) * PW'($signed(twf_im[k*TW +: TW]));
            p_im[k] = PW'(s1_re[k]) * PW'($signed(twf_im[k*TW +: TW]))
                    + PW'(s1_im[k]) * PW'($signed(twf_re[k*TW +: TW]));
            {c_re[k], q_re[k]} = rnd_sat(s2_re[k]);
            {c_im[k], q_im[k]} = rnd_sat(s2_im[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt        <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_sat   <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_re[k] <= '0;
                s1_im[k] <= '0;
                s2_re[k] <= '0;
                s2_im[k] <= '0;
            end
        end else begin
            s1_valid   <= din_valid;
            s2_valid   <= s1_valid;
            dout_valid <= s2_valid;
            if (din_valid) begin
                cnt     <= grp_idx + 5'd1;
                s1_last <= (grp_idx == LAST);
                for (int k = 0; k < LANES; k++) begin
                    s1_re[k] <= din_re[k*DW +: DW];
                    s1_im[k] <= din_im[k*DW +: DW];
                end
            end
            // Twiddle for this beat is on twf_* now, one cycle after grp_idx.
            if (s1_valid) begin
                s2_last <= s1_last;
                for (int k = 0; k < LANES; k++) begin
                    s2_re[k] <= p_re[k];
                    s2_im[k] <= p_im[k];
                end
            end
            if (s2_valid) begin
                dout_last <= s2_last;
                dout_sat  <= |{c_re, c_im};
                for (int k = 0; k < LANES; k++) begin
                    dout_re[k*DW +: DW] <= q_re[k];
                    dout_im[k*DW +: DW] <= q_im[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_twf_mul0_2.sv
// Bench for twf_mul0_2: directed vector table, frame/bubble/reset
// sequences and random traffic against a scoreboard model.
module tb_twf_mul0_2;

    localparam int L  = 16;
    localparam int DW = 13;
    localparam int TW = 9;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              din_valid = 1'b0;
    logic              din_sof = 1'b0;
    logic [L*DW-1:0]   din_re = '0;
    logic [L*DW-1:0]   din_im = '0;
    logic [4:0]        grp_idx;
    logic [L*TW-1:0]   twf_re = '0;
    logic [L*TW-1:0]   twf_im = '0;
    logic              dout_valid;
    logic              dout_last;
    logic              dout_sat;
    logic [L*DW-1:0]   dout_re;
    logic [L*DW-1:0]   dout_im;

    twf_mul0_2 dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_re     (din_re),
        .din_im     (din_im),
        .grp_idx    (grp_idx),
        .twf_re     (twf_re),
        .twf_im     (twf_im),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_sat   (dout_sat),
        .dout_re    (dout_re),
        .dout_im    (dout_im)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L*DW-1:0] re;
        logic [L*DW-1:0] im;
        logic            last;
        logic            sat;
        int              cyc;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int re;
        int im;
        int sat;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mcnt = 0;
    exp_t sbq[$];
    int va[L];
    int vb[L];
    int vc[L];
    int vd[L];
    logic [L*TW-1:0] pend_re = '0;
    logic [L*TW-1:0] pend_im = '0;
    logic [L*DW-1:0] prev_re = '0;
    logic [L*DW-1:0] prev_im = '0;
    logic            prev_last = 1'b0;
    logic            prev_sat = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [L*DW-1:0] act,
                        input logic [L*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: complex multiply, round half up by 128, clamp to 13 bits.
    function automatic int rs(input int s, output bit sat);
        int y;
        y = (s + 64) >>> 7;
        sat = 1'b0;
        if (y > 4095) begin
            y = 4095;
            sat = 1'b1;
        end else if (y < -4096) begin
            y = -4096;
            sat = 1'b1;
        end
        return y;
    endfunction

    task automatic observe();
        exp_t e;
        if (dout_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", int'(dout_valid), 0);
            end else begin
                e = sbq.pop_front();
                chk("latency", cyc, e.cyc + 3);
                chkv("dout_re", dout_re, e.re);
                chkv("dout_im", dout_im, e.im);
                chk("dout_last", int'(dout_last), int'(e.last));
                chk("dout_sat", int'(dout_sat), int'(e.sat));
                prev_re = e.re;
                prev_im = e.im;
                prev_last = e.last;
                prev_sat = e.sat;
            end
        end else begin
            chkv("hold_re", dout_re, prev_re);
            chkv("hold_im", dout_im, prev_im);
            chk("hold_last", int'(dout_last), int'(prev_last));
            chk("hold_sat", int'(dout_sat), int'(prev_sat));
            if (sbq.size() > 0 && cyc >= sbq[0].cyc + 3) begin
                chk("missing_valid", int'(dout_valid), 1);
                void'(sbq.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        din_valid = 1'b0;
        din_sof = 1'b0;
        sbq.delete();
        mcnt = 0;
        prev_re = '0;
        prev_im = '0;
        prev_last = 1'b0;
        prev_sat = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rstn = 1'b1;
        observe();
    endtask

    // Drive one cycle; the twiddle for a beat follows it by one cycle.
    task automatic beat(input bit v, input bit sof);
        exp_t e;
        int idx;
        int r;
        bit s;
        din_valid = v;
        din_sof = sof;
        twf_re = pend_re;
        twf_im = pend_im;
        e = '0;
        for (int k = 0; k < L; k++) begin
            din_re[k*DW +: DW] = DW'(va[k]);
            din_im[k*DW +: DW] = DW'(vb[k]);
            pend_re[k*TW +: TW] = TW'(vc[k]);
            pend_im[k*TW +: TW] = TW'(vd[k]);
        end
        #1;
        if (v) begin
            idx = sof ? 0 : mcnt;
            chk("grp_idx", int'(grp_idx), idx);
            mcnt = (idx + 1) % 32;
            for (int k = 0; k < L; k++) begin
                r = rs(va[k] * vc[k] - vb[k] * vd[k], s);
                e.re[k*DW +: DW] = DW'(r);
                e.sat = e.sat | s;
                r = rs(va[k] * vd[k] + vb[k] * vc[k], s);
                e.im[k*DW +: DW] = DW'(r);
                e.sat = e.sat | s;
            end
            e.last = (idx == 31);
            e.cyc = cyc;
            sbq.push_back(e);
        end
        tick();
    endtask

    task automatic set_all(input int a, input int b, input int c, input int d);
        for (int k = 0; k < L; k++) begin
            va[k] = a;
            vb[k] = b;
            vc[k] = c;
            vd[k] = d;
        end
    endtask

    task automatic set_rand();
        for (int k = 0; k < L; k++) begin
            va[k] = int'($urandom_range(0, 8191)) - 4096;
            vb[k] = int'($urandom_range(0, 8191)) - 4096;
            vc[k] = int'($urandom_range(0, 511)) - 256;
            vd[k] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    vec_t vt[10];
    logic [DW-1:0] t;
    logic [L*DW-1:0] xr;
    logic [L*DW-1:0] xi;

    initial begin
        vt[0] = '{1000, 0, 128, 0, 1000, 0, 0};
        vt[1] = '{1000, 0, 0, -128, 0, -1000, 0};
        vt[2] = '{1, 0, 64, 0, 1, 0, 0};
        vt[3] = '{-1, 0, 64, 0, 0, 0, 0};
        vt[4] = '{3, 0, -64, 0, -1, 0, 0};
        vt[5] = '{4095, 4095, 128, -128, 4095, 0, 1};
        vt[6] = '{1, 1, 128, 0, 1, 1, 0};
        vt[7] = '{-4096, 0, -128, 0, 4095, 0, 1};
        vt[8] = '{-4096, 0, 128, 0, -4096, 0, 0};
        vt[9] = '{-4096, -4096, 128, 128, 0, -4096, 1};

        set_all(0, 0, 0, 0);
        do_reset();
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_grp_idx", int'(grp_idx), 0);

        // Full frame of unity twiddles.
        set_all(1000, 0, 128, 0);
        for (int i = 0; i < 32; i++) beat(1'b1, i == 0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        chk("frame_end_valid", int'(dout_valid), 1);
        chk("frame_end_last", int'(dout_last), 1);
        beat(1'b0, 1'b0);

        // Directed vectors, each as an isolated beat.
        for (int i = 0; i < 10; i++) begin
            set_all(vt[i].a, vt[i].b, vt[i].c, vt[i].d);
            beat(1'b1, 1'b0);
            beat(1'b0, 1'b0);
            beat(1'b0, 1'b0);
            t = DW'(vt[i].re);
            xr = {L{t}};
            t = DW'(vt[i].im);
            xi = {L{t}};
            chk("vec_valid", int'(dout_valid), 1);
            chkv("vec_re", dout_re, xr);
            chkv("vec_im", dout_im, xi);
            chk("vec_sat", int'(dout_sat), vt[i].sat);
        end

        // Saturating beat immediately followed by a clean one.
        set_all(4095, 4095, 128, -128);
        beat(1'b1, 1'b0);
        set_all(1, 1, 128, 0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        chk("sat_set", int'(dout_sat), 1);
        beat(1'b0, 1'b0);
        chk("sat_clear", int'(dout_sat), 0);

        // Valid pattern 1,0,0,1.
        set_rand();
        beat(1'b1, 1'b0);
        set_rand();
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        set_rand();
        beat(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0);

        // Resync: sof arrives at group 10.
        for (int i = 0; i < 10; i++) begin
            set_rand();
            beat(1'b1, i == 0);
        end
        chk("pre_sof_idx", int'(grp_idx), 10);
        set_rand();
        beat(1'b1, 1'b1);
        set_rand();
        beat(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0);

        // Reset with two beats in flight.
        set_rand();
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        do_reset();
        chk("midrst_valid", int'(dout_valid), 0);
        chkv("midrst_re", dout_re, '0);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0);
        set_rand();
        beat(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_rand();
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 5; i++) beat(1'b0, 1'b0);
        chk("drain", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/twf_mul0_2.md
Name: twf_mul0_2

Overview:
- Stage-0_2 twiddle multiplier of the 512-point FFT datapath; directly consumes the twf0_2 twiddle fetch.
- Accepts one 16-lane complex beat per cycle from the preceding butterfly stage and drives grp_idx to twf0_2.
- Aligns each beat with twf0_2's registered twiddle output, which arrives 1 cycle after grp_idx.
- Produces rounded, saturated complex products in a 3-cycle pipeline for the next butterfly stage.

Parameters:
- LANES, 16, parallel complex lanes per beat.
- DW, 13, signed data width on both input and output.
- TW, 9, signed twiddle width; Q2.7 format, so +1.0 = 128.
- NGRP, 32, beats per frame; the group counter is 5 bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  synchronous active-low reset.
- din_valid  input  1  input beat valid; no backpressure.
- din_sof  input  1  first beat of a frame; qualified by din_valid.
- din_re  input  DW signed x LANES  input real parts.
- din_im  input  DW signed x LANES  input imaginary parts.
- grp_idx  output  5  group index driven to twf0_2.
- twf_re  input  TW signed x LANES  twiddle real parts from twf0_2.
- twf_im  input  TW signed x LANES  twiddle imaginary parts from twf0_2.
- dout_valid  output  1  output beat valid.
- dout_last  output  1  beat with group 31; qualified by dout_valid.
- dout_sat  output  1  at least one lane or component saturated in this beat.
- dout_re  output  DW signed x LANES  product real parts.
- dout_im  output  DW signed x LANES  product imaginary parts.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - Group counter cnt=0; all valid/last pipeline bits cleared.
  - Outputs: dout_valid=0, dout_last=0, dout_sat=0, dout_re=dout_im=0 in every lane.
  - grp_idx reads 0 after reset.
- Reset mid-operation: all in-flight beats are dropped; no dout_valid is ever produced for them.
- Group index generation:
  - grp_idx = din_sof ? 0 : cnt (combinational).
  - On din_valid=1: cnt <= grp_idx + 1, wrapping 31->0.
  - On din_valid=0: cnt holds and grp_idx is don't-care.
  - din_sof without din_valid is ignored.
  - din_sof mid-frame restarts the count at 0; the partial frame is not flagged.
- Pipeline (beat accepted in cycle T; twf0_2 twiddle valid in T+1):
  - S1, edge ending T: register din_re/din_im, valid, and last = (grp_idx==31).
  - S2, edge ending T+1: per lane, with a=re, b=im, c=twf_re, d=twf_im, register full-precision ac-bd and ad+bc (DW+TW+1 = 23-bit signed, no loss).
  - S3, edge ending T+2: round, saturate, register outputs.
  - dout_valid=1 during cycle T+3. Latency is exactly 3 cycles, and throughput is 1 beat/cycle.
- Rounding and saturation:
  - Round half up: y = (sum + 64) >>> 7 (arithmetic shift).
  - Clamp y to [-2^(DW-1), 2^(DW-1)-1], i.e. [-4096, 4095].
  - dout_sat = OR over all lanes and both components of the clamp-active condition.
- Bubbles:
  - Data registers in each stage load only when that stage's valid bit is 1.
  - dout_re, dout_im, dout_last and dout_sat hold their last values while dout_valid=0.
- Lane independence: lane k uses only din[k] and twf[k]; there is no cross-lane arithmetic.

Test Plan:
- Reset, then 32 contiguous beats with din_sof on beat 0, all lanes din=(1000,0), twf=(128,0):
  - grp_idx steps 0..31.
  - dout_valid rises 3 cycles after the first beat.
  - Every lane outputs (1000,0); dout_last=1 only on the 32nd output.
  - dout_sat=0 throughout.
- Multiply by -j: din=(1000,0), twf=(0,-128) -> dout=(0,-1000).
- Rounding:
  - din=(1,0), twf=(64,0) -> dout_re=1.
  - din=(-1,0), twf=(64,0) -> dout_re=0.
  - din=(3,0), twf=(-64,0) -> dout_re=-1.
- Saturation: din=(4095,4095), twf=(128,-128) -> dout=(4095,0) and dout_sat=1; next beat din=(1,1), twf=(128,0) -> dout_sat=0.
- Bubbles and resync:
  - din_valid pattern 1,0,0,1: grp_idx advances only on valid beats; outputs appear with the same gaps.
  - din_sof asserted at group 10: the next grp_idx is 0 and cnt continues from 1.
- Reset mid-operation: rstn=0 for one edge with 2 beats in flight -> no dout_valid for those beats; grp_idx=0 on the next beat.
